// File: rtl/weight_mux_seq.sv
// Sequenced N_SRC-way weight source selector with a registered, stall-safe output.
// Steps u_count beats from u_base upward (wrapping at N_SRC), one vector per valid/ready beat.
module weight_mux_seq #(
    parameter int unsigned N_weight_out = 256,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned N_SRC        = 6,
    parameter int unsigned SEL_W        = 3,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N_SRC*N_weight_out*DATA_W-1:0] weight_in,
    input  logic                                start,
    input  logic [SEL_W-1:0]                    u_base,
    input  logic [CNT_W-1:0]                    u_count,
    input  logic                                flush,
    input  logic                                out_ready,
    output logic [N_weight_out*DATA_W-1:0]      weight_out,
    output logic                                weight_valid,
    output logic [SEL_W-1:0]                    u_cur,
    output logic                                busy,
    output logic                                done
);

    localparam int unsigned VW = N_weight_out * DATA_W;

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [VW-1:0]    out_q, out_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] cur_q, cur_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [SEL_W-1:0] nxt_idx;
    logic [SEL_W-1:0] load_idx;
    logic [VW-1:0]    load_vec;
    logic             accept;

    assign accept   = valid_q & out_ready;
    assign nxt_idx  = (cur_q >= SEL_W'(N_SRC - 1)) ? '0 : cur_q + SEL_W'(1);
    assign load_idx = (state_q == StIdle) ? u_base : nxt_idx;

    // Indices at or beyond N_SRC match no source and select all zeros.
    always_comb begin
        load_vec = '0;
        for (int s = 0; s < int'(N_SRC); s++) begin
            if (load_idx == SEL_W'(s)) begin
                load_vec = weight_in[s*VW +: VW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        valid_d = valid_q;
        cur_d   = cur_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        count_d = count_q;
        case (state_q)
            StIdle: begin
                if (!flush && start) begin
                    if (u_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StRun;
                        out_d   = load_vec;
                        cur_d   = u_base;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        cnt_d   = CNT_W'(1);
                        count_d = u_count;
                    end
                end
            end
            StRun: begin
                // Flush takes priority over a same-cycle accept.
                if (flush) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (accept) begin
                    if (cnt_q == count_q) begin
                        state_d = StIdle;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        out_d = load_vec;
                        cur_d = nxt_idx;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            out_q   <= '0;
            valid_q <= 1'b0;
            cur_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            cur_q   <= cur_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
        end
    end

    assign weight_out   = out_q;
    assign weight_valid = valid_q;
    assign u_cur        = cur_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_weight_mux_seq.sv
// Self-checking bench for weight_mux_seq: table-driven sequences, hand-written corner
// cases and randomized traffic against a beat-queue reference model.
module tb_weight_mux_seq;

    localparam int NW    = 4;
    localparam int DW    = 8;
    localparam int NSRC  = 6;
    localparam int SELW  = 3;
    localparam int CNTW  = 8;
    localparam int VW    = NW * DW;

    logic                 clk;
    logic                 rst;
    logic [NSRC*VW-1:0]   weight_in;
    logic                 start;
    logic [SELW-1:0]      u_base;
    logic [CNTW-1:0]      u_count;
    logic                 flush;
    logic                 out_ready;
    logic [VW-1:0]        weight_out;
    logic                 weight_valid;
    logic [SELW-1:0]      u_cur;
    logic                 busy;
    logic                 done;

    weight_mux_seq #(
        .N_weight_out (NW),
        .DATA_W       (DW),
        .N_SRC        (NSRC),
        .SEL_W        (SELW),
        .CNT_W        (CNTW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .weight_in    (weight_in),
        .start        (start),
        .u_base       (u_base),
        .u_count      (u_count),
        .flush        (flush),
        .out_ready    (out_ready),
        .weight_out   (weight_out),
        .weight_valid (weight_valid),
        .u_cur        (u_cur),
        .busy         (busy),
        .done         (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: queue of beat indices still to be presented.
    int          q_idx[$];
    logic [31:0] m_out;
    logic [2:0]  m_cur;
    logic        m_valid;
    logic        m_done;

    typedef struct {
        logic [2:0]  base;
        logic [7:0]  count;
        logic [23:0] idx_list;
    } vec_t;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] srcval(int idx);
        if (idx < NSRC) return weight_in[idx*VW +: VW];
        return '0;
    endfunction

    function automatic logic [31:0] make_src(int s);
        return {8'(s + 1), 8'hC3, 8'(s * 17), 8'h5A};
    endfunction

    function automatic logic [31:0] exp_src(int s);
        if (s < NSRC) return make_src(s);
        return '0;
    endfunction

    // k-th beat index of a sequence starting at base.
    function automatic int beat_idx(int base, int k);
        if (k == 0) return base;
        if (base >= NSRC) return (k - 1) % NSRC;
        return (base + k) % NSRC;
    endfunction

    task automatic model_clear();
        q_idx.delete();
        m_out   = '0;
        m_cur   = '0;
        m_valid = 1'b0;
        m_done  = 1'b0;
    endtask

    task automatic model_edge();
        logic nd;
        int   idx;
        nd = 1'b0;
        if (rst) begin
            model_clear();
        end else begin
            if (m_valid) begin
                if (flush) begin
                    m_valid = 1'b0;
                    q_idx.delete();
                end else if (out_ready) begin
                    if (q_idx.size() == 0) begin
                        m_valid = 1'b0;
                        nd = 1'b1;
                    end else begin
                        idx   = q_idx.pop_front();
                        m_cur = 3'(idx);
                        m_out = srcval(idx);
                    end
                end
            end else if (start && !flush) begin
                if (u_count == 0) begin
                    nd = 1'b1;
                end else begin
                    q_idx.delete();
                    for (int k = 1; k < int'(u_count); k++) q_idx.push_back(beat_idx(int'(u_base), k));
                    m_cur   = u_base;
                    m_out   = srcval(int'(u_base));
                    m_valid = 1'b1;
                end
            end
            m_done = nd;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("cycle{valid,busy,done,cur,out}",
            {26'd0, weight_valid, busy, done, u_cur, weight_out},
            {26'd0, m_valid, m_valid, m_done, m_cur, m_out});
    endtask

    task automatic set_fixed_src();
        for (int s = 0; s < NSRC; s++) weight_in[s*VW +: VW] = make_src(s);
    endtask

    task automatic set_rand_src();
        for (int s = 0; s < NSRC; s++) weight_in[s*VW +: VW] = $urandom;
    endtask

    vec_t        tbl[5];
    logic [31:0] exp1, exp2;

    initial begin
        rst = 1'b1; start = 1'b0; u_base = '0; u_count = '0; flush = 1'b0; out_ready = 1'b0;
        weight_in = '0;
        model_clear();
        #1;
        chk("reset_state", {26'd0, weight_valid, busy, done, u_cur, weight_out}, 64'd0);
        step();
        step();
        rst = 1'b0;
        set_fixed_src();
        step();

        // base, count, expected indices (3 bits each, beat 0 in LSBs)
        tbl[0] = '{base: 3'd2, count: 8'd3, idx_list: {15'd0, 3'd4, 3'd3, 3'd2}};
        tbl[1] = '{base: 3'd4, count: 8'd8,
                   idx_list: {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5, 3'd4}};
        tbl[2] = '{base: 3'd7, count: 8'd2, idx_list: {18'd0, 3'd0, 3'd7}};
        tbl[3] = '{base: 3'd0, count: 8'd0, idx_list: 24'd0};
        tbl[4] = '{base: 3'd5, count: 8'd1, idx_list: {21'd0, 3'd5}};

        for (int i = 0; i < 5; i++) begin
            start = 1'b1; u_base = tbl[i].base; u_count = tbl[i].count; out_ready = 1'b1;
            step();
            start = 1'b0;
            for (int b = 0; b < int'(tbl[i].count); b++) begin
                chk("tbl_cur", 64'(u_cur), 64'(tbl[i].idx_list[b*3 +: 3]));
                chk("tbl_data", 64'(weight_out), 64'(exp_src(int'(tbl[i].idx_list[b*3 +: 3]))));
                chk("tbl_valid", 64'(weight_valid), 64'd1);
                step();
            end
            chk("tbl_done", 64'({done, weight_valid}), 64'b10);
            step();
            chk("tbl_done_clr", 64'(done), 64'd0);
        end

        // Async reset mid-sequence: outputs clear without a clock edge, no done later.
        start = 1'b1; u_base = 3'd1; u_count = 8'd5; out_ready = 1'b0;
        step();
        start = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_run", {26'd0, weight_valid, busy, done, u_cur, weight_out}, 64'd0);
        model_clear();
        step();
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_no_done", 64'(done), 64'd0);
        end

        // Backpressure with source changes during the stall.
        set_rand_src();
        start = 1'b1; u_base = 3'd0; u_count = 8'd4; out_ready = 1'b1;
        step();
        start = 1'b0;
        exp1 = srcval(1);
        step();
        chk("bp_cur1", 64'(u_cur), 64'd1);
        chk("bp_out1", 64'(weight_out), 64'(exp1));
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_rand_src();
            step();
            chk("bp_stall_cur", 64'(u_cur), 64'd1);
            chk("bp_stall_out", 64'(weight_out), 64'(exp1));
        end
        out_ready = 1'b1;
        exp2 = srcval(2);
        step();
        chk("bp_cur2", 64'(u_cur), 64'd2);
        chk("bp_out2", 64'(weight_out), 64'(exp2));
        step();
        chk("bp_cur3", 64'(u_cur), 64'd3);
        step();
        chk("bp_done", 64'({done, weight_valid}), 64'b10);
        step();

        // Start while busy ignored; flush on beat 2 of 5; then a clean restart.
        set_fixed_src();
        start = 1'b1; u_base = 3'd0; u_count = 8'd5; out_ready = 1'b1;
        step();
        u_base = 3'd3; u_count = 8'd1;
        step();
        chk("busy_start_ignored", 64'(u_cur), 64'd1);
        start = 1'b0; flush = 1'b1;
        step();
        chk("flush_state", 64'({weight_valid, busy, done, u_cur}), 64'({3'b000, 3'd1}));
        flush = 1'b0;
        step();
        chk("flush_no_done", 64'(done), 64'd0);
        start = 1'b1; u_base = 3'd5; u_count = 8'd2;
        step();
        start = 1'b0;
        chk("restart_cur5", 64'(u_cur), 64'd5);
        step();
        chk("restart_cur0", 64'(u_cur), 64'd0);
        step();
        chk("restart_done", 64'(done), 64'd1);
        start = 1'b1; flush = 1'b1; u_base = 3'd2; u_count = 8'd3;
        step();
        chk("idle_flush_wins", 64'({weight_valid, done}), 64'd0);
        start = 1'b0; flush = 1'b0;
        step();

        // Randomized traffic against the reference model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            set_rand_src();
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            start     = ($urandom_range(0, 3) == 0);
            u_base    = 3'($urandom_range(0, 7));
            u_count   = 8'($urandom_range(0, 10));
            rst       = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
